operand_entry: RTL
==================

// Module: operand_entry
// PURPOSE
// - Operand source for the 3-bit MegaComparator datapath. Replaces the static SW split: the user sets SW, presses ENTER, and the block latches A.
// - The user sets SW again, presses ENTER, and the block latches B. It then presents the {a,b} pair on a valid/ready handshake to the comparator stage.
// - HEX0 shows the entry state, using the same active-low 7-seg encoding the comparator display uses.
// PARAMETERS
// - WIDTH            3            operand width in bits
// - DEBOUNCE_CYCLES  500000       stable-level cycles before a button change is accepted (10 ms at 50 MHz)
// - TIMEOUT_CYCLES   250000000    WAIT_B abandon time (5 s); used only with OPERAND_ENTRY_TIMEOUT_EN
// PORTS
// - CLOCK_50    in   1      single clock, rising edge
// - RESET_N     in   1      asynchronous, active-low reset
// - SW          in   WIDTH  raw operand switches (asynchronous)
// - ENTER_N     in   1      raw pushbutton, active-low, bouncy
// - a           out  WIDTH  latched operand A
// - b           out  WIDTH  latched operand B
// - pair_valid  out  1      {a,b} pair is complete and stable
// - pair_ready  in   1      consumer accepts the pair
// - LEDR        out  3      one-hot state {HOLD,WAIT_B,WAIT_A}
// - HEX0        out  7      state glyph, active-low, bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
// - Reset (async assert, sync release) values:
//   - state=WAIT_A; a=0; b=0; pair_valid=0; LEDR=3'b001; HEX0=7'b0001000 ('A').
//   - Debounced button level=1 (released); all counters=0.
// - Synchronisation: ENTER_N and SW each pass through a 2-FF synchroniser. SW is sampled from its synchronised copy only.
// - Debounce:
//   - Counter clears whenever synced ENTER equals the debounced level.
//   - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
// - Press event: 1-cycle pulse `press` in the cycle the debounced level falls 1->0. Release produces no event. Holding the button yields exactly one press.
// - Latency: raw ENTER_N fall (clean) -> `press` = 2 + DEBOUNCE_CYCLES cycles. `press` -> register update = next rising edge.
// - FSM:
//   - WAIT_A: on press, a<=SW_sync and go to WAIT_B.
//   - WAIT_B: on press, b<=SW_sync and go to HOLD.
//   - HOLD: pair_valid=1; presses are ignored. On pair_valid&&pair_ready, go to WAIT_A; pair_valid is 0 the following cycle.
// - pair_valid is a registered output, asserted the cycle after B is latched. Once asserted it never drops without a handshake.
// - a and b stay constant while pair_valid=1. a and b keep their last values in WAIT_A and WAIT_B; they are not cleared.
// - pair_ready is don't-care outside HOLD.
// - HEX0 per state: WAIT_A 7'b0001000 'A'; WAIT_B 7'b0000011 'b'; HOLD 7'b0001100 'P'.
// - LEDR is one-hot on state. An illegal state encoding recovers to WAIT_A.
// - Reset mid-debounce or mid-entry: everything returns to reset values. A button still held at release produces no press until it is released and pressed again.
// CONFIGURATION
// - `OPERAND_ENTRY_TIMEOUT_EN` defined:
//   - A counter runs only in WAIT_B and clears on entering WAIT_B.
//   - On reaching TIMEOUT_CYCLES-1 with no press, go to WAIT_A; a is kept.
//   - A press in the same cycle as expiry wins: latch B, go to HOLD.
// - `OPERAND_ENTRY_TIMEOUT_EN` undefined: no counter; WAIT_B waits indefinitely. TIMEOUT_CYCLES is unused.
// STRUCTURE
// - operand_entry_pkg holds:
//   - state enum {WAIT_A=2'd0, WAIT_B=2'd1, HOLD=2'd2};
//   - 7-seg glyph constants SEG_A, SEG_B_LC, SEG_P (shared with comparator display code).
// - Sub-module button_debounce (params DEBOUNCE_CYCLES):
//   - ports CLOCK_50, RESET_N, btn_n_raw -> level, press;
//   - contains the synchroniser, counter and fall detector.
// - Top level holds the SW synchroniser, FSM, operand registers, optional timeout counter and display decode.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20)
// 1. Reset, idle 10 cycles -> a=0, b=0, pair_valid=0, LEDR=001, HEX0=0001000.
// 2. SW=5, clean press; SW=2, clean press; pair_ready=0 ->
//    - a=5, b=2, pair_valid=1, HEX0=0001100;
//    - pair_valid and operands held 50 cycles.
// 3. Case 2 then pair_ready=1 for 1 cycle -> pair_valid=0 next cycle, state WAIT_A, a=5/b=2 retained.
// 4. ENTER_N bounces 0/1 every 2 cycles for 20 cycles, then held 0 -> exactly one press, state WAIT_A->WAIT_B only.
// 5. Press in HOLD with pair_ready=0 -> no change to a, b, state or pair_valid.
// 6. TIMEOUT_EN defined: latch A=3, then no press for 20 cycles -> WAIT_A, HEX0=0001000, a=3. Undefined: stays in WAIT_B.
// 7. Assert RESET_N=0 mid-debounce in WAIT_B -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/operand_entry_pkg.sv
// rtl/operand_entry_pkg.sv - shared state encoding and display constants for operand_entry
//
// Purpose : entry FSM state type, one-hot LED patterns and active-low 7-seg
//           glyphs. The glyphs are the ones the comparator display code uses.
// Ports   : none (package)
package operand_entry_pkg;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // LEDR is one-hot on state, bit order {HOLD, WAIT_B, WAIT_A}
    localparam logic [2:0] LED_WAIT_A = 3'b001;
    localparam logic [2:0] LED_WAIT_B = 3'b010;
    localparam logic [2:0] LED_HOLD   = 3'b100;

    // Active-low 7-seg glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B_LC = 7'b0000011;
    localparam logic [6:0] SEG_P    = 7'b0001100;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser, debounce counter and press detector for an active-low button
//
// Purpose : turns a raw, bouncy, active-low pushbutton into a clean level and
//           a single-cycle press pulse on each accepted 1->0 transition.
// Ports   : CLOCK_50  in  clock, rising edge
//           RESET_N   in  asynchronous active-low reset
//           btn_n_raw in  raw button, active-low, asynchronous
//           level     out debounced button level (1 = released)
//           press     out 1-cycle pulse when the debounced level falls
module button_debounce
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic btn_n_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          armed;
    logic [CW-1:0] cnt;

    // The synchroniser resets to "pressed" so a button held through reset is
    // seen as held. Nothing is debounced until a real release has been
    // observed (armed), so a held button cannot produce a press on its own.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync  <= 2'b00;
            armed <= 1'b0;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn_n_raw};
            press <= 1'b0;
            if (!armed) begin
                cnt   <= '0;
                armed <= sync[1];
            end else if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
                press <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - two-press operand entry with valid/ready pair output and state display
//
// Purpose : latch operand A then B from SW on successive ENTER presses, then
//           offer {a,b} on a valid/ready handshake. LEDR/HEX0 show the state.
// Config  : OPERAND_ENTRY_TIMEOUT_EN - when defined, WAIT_B falls back to
//           WAIT_A after TIMEOUT_CYCLES without a press (a is kept).
// Ports   : CLOCK_50   in  clock, rising edge
//           RESET_N    in  asynchronous active-low reset
//           SW         in  raw operand switches (asynchronous)
//           ENTER_N    in  raw pushbutton, active-low, bouncy
//           a, b       out latched operands
//           pair_valid out {a,b} complete and stable
//           pair_ready in  consumer accepts the pair
//           LEDR       out one-hot state {HOLD,WAIT_B,WAIT_A}
//           HEX0       out active-low state glyph {g,f,e,d,c,b,a}
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] SW,
    input  logic             ENTER_N,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [2:0]       LEDR,
    output logic [6:0]       HEX0
);

    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_sync;
    logic             enter_level;
    logic             enter_fall;
    logic             enter_press;
    logic             timeout_hit;
    state_t           state;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .btn_n_raw(ENTER_N),
        .level    (enter_level),
        .press    (enter_fall)
    );

    // press is only ever raised together with a low level; the qualifier
    // keeps the FSM from acting on a pulse that disagrees with the level.
    assign enter_press = enter_fall & ~enter_level;

`ifdef OPERAND_ENTRY_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] tcnt;

    // Held at zero outside WAIT_B, so every entry into WAIT_B starts from 0.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tcnt <= '0;
        end else if (state != WAIT_B || timeout_hit) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign timeout_hit = (state == WAIT_B) && (tcnt == T_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // LEDR and HEX0 are registered alongside state so they change together.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= WAIT_A;
            a          <= '0;
            b          <= '0;
            pair_valid <= 1'b0;
            LEDR       <= LED_WAIT_A;
            HEX0       <= SEG_A;
        end else begin
            case (state)
                WAIT_A: begin
                    if (enter_press) begin
                        a     <= sw_sync;
                        state <= WAIT_B;
                        LEDR  <= LED_WAIT_B;
                        HEX0  <= SEG_B_LC;
                    end
                end
                WAIT_B: begin
                    // A press coinciding with timeout expiry takes priority.
                    if (enter_press) begin
                        b          <= sw_sync;
                        state      <= HOLD;
                        pair_valid <= 1'b1;
                        LEDR       <= LED_HOLD;
                        HEX0       <= SEG_P;
                    end else if (timeout_hit) begin
                        state <= WAIT_A;
                        LEDR  <= LED_WAIT_A;
                        HEX0  <= SEG_A;
                    end
                end
                HOLD: begin
                    if (pair_valid && pair_ready) begin
                        state      <= WAIT_A;
                        pair_valid <= 1'b0;
                        LEDR       <= LED_WAIT_A;
                        HEX0       <= SEG_A;
                    end
                end
                default: begin
                    state      <= WAIT_A;
                    pair_valid <= 1'b0;
                    LEDR       <= LED_WAIT_A;
                    HEX0       <= SEG_A;
                end
            endcase
        end
    end

endmodule
